// File: rtl/ram_bist_pkg.sv
// Shared types and the test-pattern formula for the RAM BIST master.
package ram_bist_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StWrGap,
    StRd,
    StRdGap,
    StDone
  } bist_state_e;

  // Full-width result; callers truncate to their data width.
  function automatic logic [31:0] pat(input int unsigned seed, input int unsigned step,
                                      input int unsigned p, input int unsigned a);
    return seed + a + p * step;
  endfunction

endpackage

// File: rtl/ram_bist_master_if.sv
// Single-port RAM valid/ready request bus between the BIST master and the RAM.
interface ram_bist_master_if #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned WIDTH      = 8
);
  logic                  valid;
  logic                  wr_rd;
  logic [ADDR_WIDTH-1:0] addr;
  logic [WIDTH-1:0]      wdata;
  logic [WIDTH-1:0]      rdata;
  logic                  ready;

  modport master (output valid, wr_rd, addr, wdata, input rdata, ready);
  modport slave  (input valid, wr_rd, addr, wdata, output rdata, ready);
endinterface

// File: rtl/ram_bist_pattern_gen.sv
// Combinational pattern generator: pat(p, a) = SEED + a + p*PASS_STEP mod 2**WIDTH.
module ram_bist_pattern_gen
  import ram_bist_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned PASS_W     = 2,
  parameter int unsigned SEED       = 8'hA5,
  parameter int unsigned PASS_STEP  = 8'h3C
) (
  input  logic [PASS_W-1:0]     pass_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic [WIDTH-1:0]      pat_o
);

  assign pat_o = WIDTH'(pat(SEED, PASS_STEP, 32'(pass_i), 32'(addr_i)));

endmodule

// File: rtl/ram_bist_master.sv
// RAM BIST initiator: NUM_PASSES write-then-read-compare passes over DEPTH words.
// Optional first-mismatch capture ports are enabled by defining RAM_BIST_FIRST_FAIL_EN.
module ram_bist_master
  import ram_bist_pkg::*;
#(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned NUM_PASSES = 3,
  parameter int unsigned SEED       = 8'hA5,
  parameter int unsigned PASS_STEP  = 8'h3C,
  parameter int unsigned ERR_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass_ok,
  output logic [ERR_W-1:0]      err_cnt,
`ifdef RAM_BIST_FIRST_FAIL_EN
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [WIDTH-1:0]      fail_exp,
  output logic [WIDTH-1:0]      fail_act,
`endif
  ram_bist_master_if.master     bus
);

  localparam int unsigned PASS_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [PASS_W-1:0]     LastPass = PASS_W'(NUM_PASSES - 1);

  bist_state_e           state_q;
  logic [PASS_W-1:0]     pass_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  valid_q, wr_rd_q, busy_q, done_q, pass_ok_q;
  logic [WIDTH-1:0]      wdata_q;
  logic [ERR_W-1:0]      err_q;
`ifdef RAM_BIST_FIRST_FAIL_EN
  logic [ADDR_WIDTH-1:0] fail_addr_q;
  logic [WIDTH-1:0]      fail_exp_q, fail_act_q;
`endif

  logic                  last_addr;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [PASS_W-1:0]     pg_pass;
  logic [ADDR_WIDTH-1:0] pg_addr;
  logic [WIDTH-1:0]      pat_w;
  logic                  mismatch;

  // Outputs are registered, so the generator looks one step ahead to the
  // (pass, addr) the next request will carry; in RD it gives the current one.
  always_comb begin
    last_addr = (addr_q == LastAddr);
    next_addr = last_addr ? '0 : addr_q + ADDR_WIDTH'(1);
    pg_pass   = pass_q;
    pg_addr   = addr_q;
    case (state_q)
      StIdle: begin
        pg_pass = '0;
        pg_addr = '0;
      end
      StWrGap: pg_addr = next_addr;
      StRdGap: begin
        pg_addr = next_addr;
        if (last_addr) pg_pass = pass_q + PASS_W'(1);
      end
      default: ;
    endcase
  end

  ram_bist_pattern_gen #(
    .WIDTH      (WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .PASS_W     (PASS_W),
    .SEED       (SEED),
    .PASS_STEP  (PASS_STEP)
  ) u_pattern_gen (
    .pass_i (pg_pass),
    .addr_i (pg_addr),
    .pat_o  (pat_w)
  );

  assign mismatch = (bus.rdata != pat_w);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      pass_q      <= '0;
      addr_q      <= '0;
      valid_q     <= 1'b0;
      wr_rd_q     <= 1'b0;
      wdata_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_ok_q   <= 1'b1;
      err_q       <= '0;
`ifdef RAM_BIST_FIRST_FAIL_EN
      fail_addr_q <= '0;
      fail_exp_q  <= '0;
      fail_act_q  <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q     <= StWr;
            busy_q      <= 1'b1;
            pass_q      <= '0;
            addr_q      <= '0;
            err_q       <= '0;
            pass_ok_q   <= 1'b1;
            valid_q     <= 1'b1;
            wr_rd_q     <= 1'b1;
            wdata_q     <= pat_w;
`ifdef RAM_BIST_FIRST_FAIL_EN
            fail_addr_q <= '0;
            fail_exp_q  <= '0;
            fail_act_q  <= '0;
`endif
          end
        end
        StWr: begin
          if (bus.ready) begin
            valid_q <= 1'b0;
            state_q <= StWrGap;
          end
        end
        StWrGap: begin
          addr_q  <= next_addr;
          valid_q <= 1'b1;
          if (last_addr) begin
            wr_rd_q <= 1'b0;
            state_q <= StRd;
          end else begin
            wdata_q <= pat_w;
            state_q <= StWr;
          end
        end
        StRd: begin
          if (bus.ready) begin
            valid_q <= 1'b0;
            state_q <= StRdGap;
            if (mismatch) begin
              if (err_q != '1) err_q <= err_q + ERR_W'(1);
              pass_ok_q <= 1'b0;
`ifdef RAM_BIST_FIRST_FAIL_EN
              // pass_ok still set means this is the run's first mismatch.
              if (pass_ok_q) begin
                fail_addr_q <= addr_q;
                fail_exp_q  <= pat_w;
                fail_act_q  <= bus.rdata;
              end
`endif
            end
          end
        end
        StRdGap: begin
          addr_q <= next_addr;
          if (!last_addr) begin
            valid_q <= 1'b1;
            state_q <= StRd;
          end else if (pass_q == LastPass) begin
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            pass_q  <= pass_q + PASS_W'(1);
            valid_q <= 1'b1;
            wr_rd_q <= 1'b1;
            wdata_q <= pat_w;
            state_q <= StWr;
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.valid = valid_q;
  assign bus.wr_rd = wr_rd_q;
  assign bus.addr  = addr_q;
  assign bus.wdata = wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass_ok   = pass_ok_q;
  assign err_cnt   = err_q;
`ifdef RAM_BIST_FIRST_FAIL_EN
  assign fail_addr = fail_addr_q;
  assign fail_exp  = fail_exp_q;
  assign fail_act  = fail_act_q;
`endif

endmodule

// File: tb/tb_ram_bist_master.sv
// Self-checking bench for ram_bist_master: RAM model, expected-request queue and directed runs.
// Extra checks on the first-mismatch ports when RAM_BIST_FIRST_FAIL_EN is defined.
module tb_ram_bist_master;

  localparam int DEPTH = 16;
  localparam int WIDTH = 8;
  localparam int AW    = 4;
  localparam int NP    = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, busy, done, pass_ok;
  logic [7:0] err_cnt;
  logic       start4, busy4, done4, pass_ok4;
  logic [3:0] err4;
`ifdef RAM_BIST_FIRST_FAIL_EN
  logic [AW-1:0]    fail_addr, fail_addr4;
  logic [WIDTH-1:0] fail_exp, fail_act, fail_exp4, fail_act4;
`endif

  always #5 clk = ~clk;

  ram_bist_master_if #(.ADDR_WIDTH(AW), .WIDTH(WIDTH)) bus  ();
  ram_bist_master_if #(.ADDR_WIDTH(AW), .WIDTH(WIDTH)) bus4 ();

  ram_bist_master #(
    .DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_WIDTH(AW), .NUM_PASSES(NP),
    .SEED(8'hA5), .PASS_STEP(8'h3C), .ERR_W(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .pass_ok(pass_ok), .err_cnt(err_cnt),
`ifdef RAM_BIST_FIRST_FAIL_EN
    .fail_addr(fail_addr), .fail_exp(fail_exp), .fail_act(fail_act),
`endif
    .bus(bus)
  );

  ram_bist_master #(
    .DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_WIDTH(AW), .NUM_PASSES(NP),
    .SEED(8'hA5), .PASS_STEP(8'h3C), .ERR_W(4)
  ) dut4 (
    .clk(clk), .rst(rst), .start(start4), .busy(busy4), .done(done4),
    .pass_ok(pass_ok4), .err_cnt(err4),
`ifdef RAM_BIST_FIRST_FAIL_EN
    .fail_addr(fail_addr4), .fail_exp(fail_exp4), .fail_act(fail_act4),
`endif
    .bus(bus4)
  );

  // Second instance: zero-wait responder whose reads always return 00.
  assign bus4.ready = bus4.valid;
  assign bus4.rdata = '0;

  // RAM model for the main instance.
  logic [7:0] mem [DEPTH];
  int  ready_delay = 0;
  int  wcnt        = 0;
  bit  corrupt_en  = 0;
  int  rd_idx      = 0;
  int  rd_base     = 0;

  assign bus.ready = bus.valid && (wcnt >= ready_delay);
  assign bus.rdata = mem[bus.addr] ^ {7'b0, corrupt_en && ((rd_idx - rd_base) == DEPTH + 5)};

  always @(posedge clk) begin
    if (bus.valid && !bus.ready) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (bus.valid && bus.ready) begin
      if (bus.wr_rd) mem[bus.addr] <= bus.wdata;
      else rd_idx <= rd_idx + 1;
    end
  end

  typedef struct {bit wr; int p; int a;} req_t;
  req_t q[$];

  int checks = 0;
  int errors = 0;

  function automatic logic [7:0] pat_ref(input int p, input int a);
    return 8'(32'hA5 + a + p * 32'h3C);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Request-stream checker against the expected queue.
  bit         chk_en = 0, gap_exp = 0, stalled = 0, mfail_seen = 0;
  int         model_err = 0, xfers = 0, mfail_a = 0;
  logic [7:0] mfail_exp, mfail_act, seen_first_wd, seen_p1a3_wd;

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      if (stalled) check("stall_valid_hold", bus.valid, 1);
      stalled = 0;
      if (gap_exp) begin
        check("gap_valid_low", bus.valid, 0);
        gap_exp = 0;
      end else if (bus.valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_xfer: got valid=1 addr=%0h expected no request", bus.addr);
        end else begin
          check("wr_rd", bus.wr_rd, q[0].wr);
          check("addr", bus.addr, q[0].a);
          if (q[0].wr) check("wdata", bus.wdata, pat_ref(q[0].p, q[0].a));
          if (bus.ready) begin
            xfers++;
            gap_exp = 1;
            if (q[0].wr && q[0].p == 0 && q[0].a == 0) seen_first_wd = bus.wdata;
            if (q[0].wr && q[0].p == 1 && q[0].a == 3) seen_p1a3_wd = bus.wdata;
            if (!q[0].wr && bus.rdata !== pat_ref(q[0].p, q[0].a)) begin
              model_err++;
              if (!mfail_seen) begin
                mfail_seen = 1;
                mfail_a    = q[0].a;
                mfail_exp  = pat_ref(q[0].p, q[0].a);
                mfail_act  = bus.rdata;
              end
            end
            void'(q.pop_front());
          end else begin
            stalled = 1;
          end
        end
      end
    end
  end

  task automatic run(input bit corrupt, input int delay, input bit mid_start, input int exp_cycles);
    int n;
    bit got;
    corrupt_en  = corrupt;
    ready_delay = delay;
    q.delete();
    for (int p = 0; p < NP; p++) begin
      for (int a = 0; a < DEPTH; a++) q.push_back('{wr: 1'b1, p: p, a: a});
      for (int a = 0; a < DEPTH; a++) q.push_back('{wr: 1'b0, p: p, a: a});
    end
    model_err  = 0;
    mfail_seen = 0;
    gap_exp    = 0;
    stalled    = 0;
    xfers      = 0;
    rd_base    = rd_idx;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk_en = 1;
    n   = 0;
    got = 0;
    while (!got && n < 2000) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        check("start_clears_err", err_cnt, 0);
        check("start_sets_pass_ok", pass_ok, 1);
        check("busy_after_start", busy, 1);
      end
      if (mid_start && n == 50) start = 1'b1;
      if (mid_start && n == 52) start = 1'b0;
      if (done) got = 1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done after %0d cycles expected %0d", n, exp_cycles);
    end
    check("run_cycles", n, exp_cycles);
    check("busy_during_done", busy, 1);
    check("queue_drained", q.size(), 0);
    check("err_cnt_model", err_cnt, model_err);
    check("pass_ok_model", pass_ok, model_err == 0);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("busy_dropped", busy, 0);
    repeat (5) @(negedge clk);
    chk_en = 0;
  endtask

  initial begin
    int n;
    rst    = 1'b1;
    start  = 1'b0;
    start4 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", bus.valid, 0);
    check("rst_wr_rd", bus.wr_rd, 0);
    check("rst_addr", bus.addr, 0);
    check("rst_wdata", bus.wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass_ok", pass_ok, 1);
    check("rst_err_cnt", err_cnt, 0);
    @(negedge clk);
    rst = 1'b0;

    // Clean zero-wait run with an ignored start pulse mid-run.
    run(1'b0, 0, 1'b1, 4 * NP * DEPTH + 1);
    check("xfer_count", xfers, 2 * NP * DEPTH);
    check("first_wdata", seen_first_wd, 8'hA5);
    check("p1_a3_wdata", seen_p1a3_wd, 8'hE4);
    check("clean_pass_ok", pass_ok, 1);
    check("clean_err_cnt", err_cnt, 0);

    // Bit 0 flipped on pass 1 read of address 5.
    run(1'b1, 0, 1'b0, 4 * NP * DEPTH + 1);
    check("corrupt_err_cnt", err_cnt, 1);
    check("corrupt_pass_ok", pass_ok, 0);
`ifdef RAM_BIST_FIRST_FAIL_EN
    check("fail_addr", fail_addr, 5);
    check("fail_exp", fail_exp, 8'hE6);
    check("fail_act", fail_act, 8'hE7);
    check("fail_addr_model", fail_addr, mfail_a);
    check("fail_act_model", fail_act, mfail_act);
    check("fail_exp_model", fail_exp, mfail_exp);
`endif

    // Responder stalls 3 cycles per request; rerun clears previous error.
    run(1'b0, 3, 1'b0, 5 * 2 * NP * DEPTH + 1);
    check("stall_pass_ok", pass_ok, 1);
    check("stall_err_cnt", err_cnt, 0);
`ifdef RAM_BIST_FIRST_FAIL_EN
    check("fail_addr_cleared", fail_addr, 0);
    check("fail_act_cleared", fail_act, 0);
`endif
    ready_delay = 0;

    // Narrow error counter saturates.
    @(negedge clk);
    start4 = 1'b1;
    @(posedge clk);
    #1 start4 = 1'b0;
    n = 0;
    while (!done4 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("sat_done_cycles", n, 4 * NP * DEPTH + 1);
    check("sat_err_cnt", err4, 4'hF);
    check("sat_pass_ok", pass_ok4, 0);

    // Asynchronous reset while a write request is outstanding.
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_valid", bus.valid, 1);
    check("pre_rst_wr_rd", bus.wr_rd, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", bus.valid, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_err_cnt", err_cnt, 0);
    check("async_rst_pass_ok", pass_ok, 1);
    check("async_rst_addr", bus.addr, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_after_rst_valid", bus.valid, 0);
      check("idle_after_rst_busy", busy, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
